// File: rtl/riscv_dmem_responder_if.sv
// Load/store port between the core's Memory Access stage (master) and the
// data-memory responder (slave).
interface riscv_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding data-memory responder: accept, wait LATENCY cycles,
// perform a byte-lane load/store on an internal word array, hold the response.
module riscv_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  riscv_dmem_responder_if.slave dmem
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rspRdata_q, rspRdata_d;
  logic        rspError_q, rspError_d;

  logic             doAccess;
  logic [IDX_W-1:0] wordIdx;
  logic             outOfRange;
  logic             illegalOp;
  logic             misaligned;
  logic             accError;
  logic [31:0]      rdWord;
  logic [31:0]      byteSel;
  logic [31:0]      halfSel;
  logic [31:0]      loadData;
  logic [3:0]       byteEn;
  logic [31:0]      wrData;
  logic             wrEn;

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rspRdata_q <= '0;
      rspError_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rspRdata_q <= rspRdata_d;
      rspError_q <= rspError_d;
    end
  end

  // doAccess marks the edge that enters RESP; the _d fields then hold the operation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    doAccess = 1'b0;
    case (state_q)
      IDLE: begin
        if (dmem.req_valid) begin
          we_d     = dmem.req_we;
          funct3_d = dmem.req_funct3;
          addr_d   = dmem.req_addr;
          wdata_d  = dmem.req_wdata;
          if (LATENCY == 0) begin
            state_d  = RESP;
            doAccess = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = RESP;
          doAccess = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (dmem.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wordIdx    = addr_d[IDX_W+1:2];
    outOfRange = addr_d[31:2] >= 30'(DEPTH_WORDS);
    if (we_d) begin
      illegalOp = funct3_d > 3'b010;
    end else begin
      illegalOp = (funct3_d == 3'b011) || (funct3_d == 3'b110) || (funct3_d == 3'b111);
    end
    misaligned = ((funct3_d[1:0] == 2'b01) && addr_d[0]) ||
                 ((funct3_d == 3'b010) && (addr_d[1:0] != 2'b00));
    accError   = illegalOp || misaligned || outOfRange;

    rdWord  = outOfRange ? 32'h0 : mem[wordIdx];
    byteSel = rdWord >> {addr_d[1:0], 3'b000};
    halfSel = rdWord >> {addr_d[1], 4'b0000};
    case (funct3_d)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel[7:0]};
      3'b100:  loadData = {24'h0, byteSel[7:0]};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel[15:0]};
      3'b101:  loadData = {16'h0, halfSel[15:0]};
      3'b010:  loadData = rdWord;
      default: loadData = 32'h0;
    endcase

    case (funct3_d[1:0])
      2'b00: begin
        byteEn = 4'b0001 << addr_d[1:0];
        wrData = {4{wdata_d[7:0]}};
      end
      2'b01: begin
        byteEn = 4'b0011 << {addr_d[1], 1'b0};
        wrData = {2{wdata_d[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrData = wdata_d;
      end
    endcase

    wrEn       = doAccess && we_d && !accError;
    rspRdata_d = rspRdata_q;
    rspError_d = rspError_q;
    if (doAccess) begin
      rspError_d = accError;
      rspRdata_d = (accError || we_d) ? 32'h0 : loadData;
    end
  end

  // The array is deliberately left without reset; rst only blocks a commit.
  always_ff @(posedge clk) begin
    if (wrEn && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  assign dmem.req_ready = (state_q == IDLE);
  assign dmem.rsp_valid = (state_q == RESP);
  assign dmem.rsp_rdata = rspRdata_q;
  assign dmem.rsp_error = rspError_q;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Randomized and directed bench for riscv_dmem_responder against a byte-array
// reference model of RISC-V load/store semantics.
module tb_riscv_dmem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 3;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_dmem_responder_if dmem();

  riscv_dmem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dmem(dmem)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] refMem [DEPTH_WORDS*4];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit refError(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    bit legal;
    if (we) legal = f3 inside {F_B, F_H, F_W};
    else    legal = f3 inside {F_B, F_H, F_W, F_BU, F_HU};
    if (!legal) return 1'b1;
    if ((addr % accessSize(f3)) != 0) return 1'b1;
    return (addr / 4) >= DEPTH_WORDS;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr);
    int size = accessSize(f3);
    logic [31:0] v = 32'h0;
    logic [31:0] mask;
    for (int i = 0; i < size; i++) v = v | (32'(refMem[int'(addr) + i]) << (8 * i));
    if (size < 4 && !f3[2]) begin
      mask = (32'h1 << (8 * size)) - 32'h1;
      if (v[8*size-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic refStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    for (int i = 0; i < accessSize(f3); i++) refMem[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  task automatic applyStimulus(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    int guard = 0;
    rdata = 32'h0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clk);
    dmem.req_we     = we;
    dmem.req_funct3 = f3;
    dmem.req_addr   = addr;
    dmem.req_wdata  = wdata;
    dmem.req_valid  = 1'b1;
    while (!dmem.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!dmem.req_ready) begin
      dmem.req_valid = 1'b0;
      checkOutput("acceptTimeout", 32'(dmem.req_ready), 32'h1);
      return;
    end
    @(posedge clk);
    #1 dmem.req_valid = 1'b0;
    lat = 1;
    while (!dmem.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!dmem.rsp_valid) begin
      checkOutput("rspTimeout", 32'(dmem.rsp_valid), 32'h1);
      return;
    end
    rdata = dmem.rsp_rdata;
    err   = dmem.rsp_error;
    dmem.rsp_ready = 1'b1;
    @(posedge clk);
    #1 dmem.rsp_ready = 1'b0;
    checkOutput("idleAfterResp", 32'(dmem.req_ready), 32'h1);
  endtask

  task automatic doTxn(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    bit          expErr  = refError(we, f3, addr);
    logic [31:0] expData = (expErr || we) ? 32'h0 : refLoad(f3, addr);
    int          lat;
    applyStimulus(we, f3, addr, wdata, rdata, err, lat);
    checkOutput({tag, ".rdata"}, rdata, expData);
    checkOutput({tag, ".error"}, 32'(err), 32'(expErr));
    checkOutput({tag, ".latency"}, 32'(lat), 32'(LATENCY + 1));
    if (we && !expErr) refStore(f3, addr, wdata);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] expHeld;
    logic [31:0] w40;
    int          guard;

    dmem.req_valid  = 1'b0;
    dmem.req_we     = 1'b0;
    dmem.req_funct3 = 3'b000;
    dmem.req_addr   = 32'h0;
    dmem.req_wdata  = 32'h0;
    dmem.rsp_ready  = 1'b0;

    @(negedge clk);
    checkOutput("rst.reqReady", 32'(dmem.req_ready), 32'h1);
    checkOutput("rst.rspValid", 32'(dmem.rsp_valid), 32'h0);
    checkOutput("rst.rspRdata", dmem.rsp_rdata, 32'h0);
    checkOutput("rst.rspError", 32'(dmem.rsp_error), 32'h0);
    rst = 1'b0;

    for (int w = 0; w < 32; w++) doTxn("init", 1'b1, F_W, 32'(w * 4), $urandom, rd, er);

    // Reset in the middle of WAIT must drop the pending store.
    @(negedge clk);
    dmem.req_we = 1'b1; dmem.req_funct3 = F_W; dmem.req_addr = 32'h10;
    dmem.req_wdata = 32'h11223344; dmem.req_valid = 1'b1;
    @(posedge clk);
    #1 dmem.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midWait.rspValid", 32'(dmem.rsp_valid), 32'h0);
    checkOutput("midWait.reqReady", 32'(dmem.req_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    doTxn("lwAfterReset", 1'b0, F_W, 32'h10, 32'h0, rd, er);

    doTxn("sw20", 1'b1, F_W, 32'h20, 32'hDEADBEEF, rd, er);
    doTxn("lw20", 1'b0, F_W, 32'h20, 32'h0, rd, er);
    checkOutput("lw20.const", rd, 32'hDEADBEEF);

    doTxn("sw30", 1'b1, F_W, 32'h30, 32'h0, rd, er);
    doTxn("sb32", 1'b1, F_B, 32'h32, 32'h80, rd, er);
    doTxn("lw30", 1'b0, F_W, 32'h30, 32'h0, rd, er);
    checkOutput("lw30.const", rd, 32'h00800000);
    doTxn("lb32", 1'b0, F_B, 32'h32, 32'h0, rd, er);
    checkOutput("lb32.const", rd, 32'hFFFFFF80);
    doTxn("lbu32", 1'b0, F_BU, 32'h32, 32'h0, rd, er);
    checkOutput("lbu32.const", rd, 32'h00000080);

    doTxn("sh42", 1'b1, F_H, 32'h42, 32'h8001, rd, er);
    doTxn("lh42", 1'b0, F_H, 32'h42, 32'h0, rd, er);
    checkOutput("lh42.const", rd, 32'hFFFF8001);
    doTxn("lhu42", 1'b0, F_HU, 32'h42, 32'h0, rd, er);
    checkOutput("lhu42.const", rd, 32'h00008001);
    doTxn("lw40", 1'b0, F_W, 32'h40, 32'h0, rd, er);
    checkOutput("lw40.upper", {16'h0, rd[31:16]}, 32'h00008001);
    w40 = rd;

    doTxn("errLw41", 1'b0, F_W, 32'h41, 32'h0, rd, er);
    checkOutput("errLw41.flag", 32'(er), 32'h1);
    doTxn("errSh43", 1'b1, F_H, 32'h43, 32'hFFFF, rd, er);
    checkOutput("errSh43.flag", 32'(er), 32'h1);
    doTxn("errF3", 1'b0, 3'b111, 32'h40, 32'h0, rd, er);
    checkOutput("errF3.flag", 32'(er), 32'h1);
    doTxn("errRange", 1'b1, F_W, 32'(DEPTH_WORDS * 4), 32'hCAFEF00D, rd, er);
    checkOutput("errRange.flag", 32'(er), 32'h1);
    doTxn("lw40Again", 1'b0, F_W, 32'h40, 32'h0, rd, er);
    checkOutput("lw40Again.same", rd, w40);

    // Hold the response while a store to 0x50 is pending; it must never be taken.
    expHeld = refLoad(F_W, 32'h40);
    @(negedge clk);
    dmem.req_we = 1'b0; dmem.req_funct3 = F_W; dmem.req_addr = 32'h40; dmem.req_valid = 1'b1;
    @(posedge clk);
    #1;
    dmem.req_we = 1'b1; dmem.req_addr = 32'h50; dmem.req_wdata = 32'hA5A5A5A5;
    guard = 0;
    while (!dmem.rsp_valid && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    checkOutput("bp.rspValid", 32'(dmem.rsp_valid), 32'h1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp.heldRdata", dmem.rsp_rdata, expHeld);
      checkOutput("bp.heldValid", 32'(dmem.rsp_valid), 32'h1);
      checkOutput("bp.reqReady", 32'(dmem.req_ready), 32'h0);
    end
    dmem.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    dmem.rsp_ready = 1'b0;
    dmem.req_valid = 1'b0;
    checkOutput("bp.releaseIdle", 32'(dmem.req_ready), 32'h1);
    checkOutput("bp.releaseValid", 32'(dmem.rsp_valid), 32'h0);
    doTxn("bp.lw50", 1'b0, F_W, 32'h50, 32'h0, rd, er);

    for (int n = 0; n < 300; n++) begin
      bit          we   = 1'($urandom_range(0, 1));
      logic [2:0]  f3;
      logic [31:0] addr;
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: f3 = F_B;
          1: f3 = F_H;
          2: f3 = F_W;
          3: f3 = F_BU;
          default: f3 = F_HU;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) < 9) addr = 32'($urandom_range(0, 127));
      else                          addr = 32'(DEPTH_WORDS * 4) + 32'($urandom_range(0, 4095));
      doTxn("rand", we, f3, addr, $urandom, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
